aqed_fifo_reader: RTL and testbench

Read-side end of the A-QED FIFO harness. Drains a FIFO-mode `memory_core` (mode 1, tile enabled, no chaining) by issuing read enables. It pairs each returned word with its position in the write stream and captures the original and duplicate transactions. It then raises `qed_done` / `qed_check`, plus a response-bound flag and protocol-error flags. It sits between the core's `data_out` / `valid_out` / `ren_in` pins and the formal property layer, mirroring the write-side injector that drives `data_in` / `wen_in`.

---
 rtl/aqed_fifo_reader.sv | 208 ++++++++++++++++++++
 tb/tb_aqed_fifo_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aqed_fifo_reader.sv
// aqed_fifo_reader: read-side end of the A-QED FIFO harness.
// Issues core read enables and pairs each returned word with its write-stream index.
// It captures the original word and compares the duplicate against it.
// It also tracks a response bound and flags data-presence, overflow and config errors.
// Ports:
//   clk, reset (async, active-low), clk_en
//   depth, rdy_in, wr_fire, orig_idx, dup_idx   : configuration and stimulus
//   fifo_data, fifo_valid, ren_out               : memory_core read side
//   occupancy, rd_count                          : stream counters
//   orig_done, orig_data, qed_done, qed_check    : capture / compare results
//   bound_fail, err_spurious, err_missing,
//   err_overflow, cfg_err                        : sticky flags
module aqed_fifo_reader #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [15:0]       depth,
    input  logic              rdy_in,
    input  logic              wr_fire,
    input  logic [IDX_W-1:0]  orig_idx,
    input  logic [IDX_W-1:0]  dup_idx,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_valid,
    output logic              ren_out,
    output logic [IDX_W-1:0]  occupancy,
    output logic [IDX_W-1:0]  rd_count,
    output logic              orig_done,
    output logic [DATA_W-1:0] orig_data,
    output logic              qed_done,
    output logic              qed_check,
    output logic              bound_fail,
    output logic              err_spurious,
    output logic              err_missing,
    output logic              err_overflow,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        SEEK_ORIG,
        SEEK_DUP,
        DONE
    } state_e;

    localparam logic [IDX_W-1:0] ONE  = 1;
    localparam logic [IDX_W:0]   ONE1 = 1;

    state_e state_q, state_d;

    logic [IDX_W-1:0]  occ_q, occ_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic [IDX_W-1:0]  wseen_q, wseen_d;
    logic [IDX_W-1:0]  iss_q, iss_d;
    logic              pend_q, pend_d;
    logic              odone_q, odone_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              qdone_q, qdone_d;
    logic              qchk_q, qchk_d;
    logic              bf_q, bf_d;
    logic              spur_q, spur_d;
    logic              miss_q, miss_d;
    logic              ovf_q, ovf_d;
    logic              cfg_q, cfg_d;

    logic              ren;
    logic              armed;
    logic [IDX_W-1:0]  depth_x;
    logic [IDX_W+1:0]  limit;

    always_comb begin
        depth_x = IDX_W'(depth);
        // 4*depth at IDX_W+2 bits so the bound check can never wrap
        limit   = (IDX_W+2)'({depth, 2'b00});
        armed   = {1'b0, wseen_q} >= ({1'b0, orig_idx} + ONE1);
        ren     = clk_en & rdy_in & (occ_q != '0) & (state_q != DONE);
    end

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        rd_d    = rd_q;
        wseen_d = wseen_q;
        iss_d   = iss_q;
        pend_d  = pend_q;
        odone_d = odone_q;
        odata_d = odata_q;
        qdone_d = qdone_q;
        qchk_d  = qchk_q;
        bf_d    = bf_q;
        spur_d  = spur_q;
        miss_d  = miss_q;
        ovf_d   = ovf_q;
        cfg_d   = cfg_q | (dup_idx <= orig_idx);

        if (clk_en) begin
            // pend marks the cycle in which returned data is expected
            pend_d = ren;

            if (wr_fire && !ren) begin
                if (occ_q >= depth_x) begin
                    ovf_d = 1'b1;
                    occ_d = depth_x;
                end else if (occ_q != '1) begin
                    occ_d = occ_q + ONE;
                end
            end else if (ren && !wr_fire) begin
                occ_d = occ_q - ONE;
            end

            if (wr_fire && wseen_q != '1) begin
                wseen_d = wseen_q + ONE;
            end

            if (ren && !odone_q && armed && iss_q != '1) begin
                iss_d = iss_q + ONE;
            end

            if (({2'b00, iss_q} >= limit) && !odone_q) begin
                bf_d = 1'b1;
            end

            if (pend_q && !fifo_valid) begin
                miss_d = 1'b1;
            end

            if (!pend_q && fifo_valid) begin
                spur_d = 1'b1;
            end

            if (pend_q && fifo_valid) begin
                if (rd_q != '1) begin
                    rd_d = rd_q + ONE;
                end
                unique case (state_q)
                    SEEK_ORIG: begin
                        if (rd_q == orig_idx) begin
                            odata_d = fifo_data;
                            odone_d = 1'b1;
                            state_d = SEEK_DUP;
                        end
                    end
                    SEEK_DUP: begin
                        // a bad index pair parks the block in SEEK_DUP
                        if (rd_q == dup_idx && !cfg_d) begin
                            qdone_d = 1'b1;
                            qchk_d  = (fifo_data == odata_q);
                            state_d = DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEEK_ORIG;
            occ_q   <= '0;
            rd_q    <= '0;
            wseen_q <= '0;
            iss_q   <= '0;
            pend_q  <= 1'b0;
            odone_q <= 1'b0;
            odata_q <= '0;
            qdone_q <= 1'b0;
            qchk_q  <= 1'b0;
            bf_q    <= 1'b0;
            spur_q  <= 1'b0;
            miss_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            rd_q    <= rd_d;
            wseen_q <= wseen_d;
            iss_q   <= iss_d;
            pend_q  <= pend_d;
            odone_q <= odone_d;
            odata_q <= odata_d;
            qdone_q <= qdone_d;
            qchk_q  <= qchk_d;
            bf_q    <= bf_d;
            spur_q  <= spur_d;
            miss_q  <= miss_d;
            ovf_q   <= ovf_d;
            cfg_q   <= cfg_d;
        end
    end

    assign ren_out      = ren;
    assign occupancy    = occ_q;
    assign rd_count     = rd_q;
    assign orig_done    = odone_q;
    assign orig_data    = odata_q;
    assign qed_done     = qdone_q;
    assign qed_check    = qchk_q;
    assign bound_fail   = bf_q;
    assign err_spurious = spur_q;
    assign err_missing  = miss_q;
    assign err_overflow = ovf_q;
    assign cfg_err      = cfg_q;

endmodule

// File: tb/tb_aqed_fifo_reader.sv
// tb_aqed_fifo_reader: self-checking bench for aqed_fifo_reader.
// Models the FIFO core with a one-cycle read latency and scoreboards the captures.
module tb_aqed_fifo_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b0;
    logic [15:0] depth = 16'd4;
    logic        rdy_in = 1'b0;
    logic        wr_fire = 1'b0;
    logic [16:0] orig_idx = '0;
    logic [16:0] dup_idx = '0;
    logic [15:0] fifo_data = '0;
    logic        fifo_valid = 1'b0;
    logic        ren_out;
    logic [16:0] occupancy;
    logic [16:0] rd_count;
    logic        orig_done;
    logic [15:0] orig_data;
    logic        qed_done;
    logic        qed_check;
    logic        bound_fail;
    logic        err_spurious;
    logic        err_missing;
    logic        err_overflow;
    logic        cfg_err;

    aqed_fifo_reader #(.DATA_W(16), .IDX_W(17)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .depth(depth),
        .rdy_in(rdy_in), .wr_fire(wr_fire), .orig_idx(orig_idx),
        .dup_idx(dup_idx), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
        .ren_out(ren_out), .occupancy(occupancy), .rd_count(rd_count),
        .orig_done(orig_done), .orig_data(orig_data), .qed_done(qed_done),
        .qed_check(qed_check), .bound_fail(bound_fail),
        .err_spurious(err_spurious), .err_missing(err_missing),
        .err_overflow(err_overflow), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] depth;
        int orig; int dup; int nwr;
        bit rdy; bit vld; bit dup_same; int ncyc;
        bit e_odone; bit e_qdone; bit e_qchk; bit e_ovf;
        bit e_miss; bit e_cfg; bit e_bf;
        int e_occ; int e_rd; bit e_ren; int e_lat; int e_bfr;
    } vec_t;

    vec_t vecs[5];

    int nchk = 0;
    int nerr = 0;

    logic [15:0] mq[$];
    logic [15:0] sb_orig[$];
    bit          sb_chk[$];
    bit          rtn_pend;
    logic [15:0] rtn_word;
    bit          vld_en;
    logic [15:0] orig_word;
    int widx, cyc, ren_cnt, ren_dis, first_ren, qed_cyc, bf_reads;
    bit ren_any, odone_seen, qdone_seen;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] d, input int o,
                            input int dp, input bit keep);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clk_en = 1'b0;
        rdy_in = 1'b0;
        wr_fire = 1'b0;
        fifo_valid = 1'b0;
        depth = d;
        orig_idx = 17'(o);
        dup_idx = 17'(dp);
        if (!keep) begin
            rtn_pend = 1'b0;
            mq.delete();
        end
        sb_orig.delete();
        sb_chk.delete();
        orig_word = '0;
        widx = 0; cyc = 0; ren_cnt = 0; ren_dis = 0;
        first_ren = -1; qed_cyc = -1; bf_reads = -1;
        ren_any = 0; odone_seen = 0; qdone_seen = 0;
        #2;
        reset = 1'b1;
    endtask

    task automatic step(input bit wr, input logic [15:0] wd,
                        input bit rdy, input bit en, input int o,
                        input int dp);
        bit ren;
        clk_en = en;
        rdy_in = rdy;
        wr_fire = wr;
        fifo_valid = rtn_pend & en & vld_en;
        fifo_data = rtn_pend ? rtn_word : 16'h0;
        @(negedge clk);
        ren = ren_out;
        if (ren) begin
            ren_any = 1;
            ren_cnt++;
            if (first_ren < 0) first_ren = cyc;
            if (!en) ren_dis++;
        end
        if (en && rtn_pend) rtn_pend = 1'b0;
        if (ren) begin
            rtn_word = (mq.size() > 0) ? mq.pop_front() : 16'h0;
            rtn_pend = 1'b1;
        end
        if (wr) begin
            mq.push_back(wd);
            if (widx == o) begin
                sb_orig.push_back(wd);
                orig_word = wd;
            end
            if (widx == dp && dp > o) sb_chk.push_back(wd == orig_word);
            widx++;
        end
        @(posedge clk);
        #1;
        if (orig_done && !odone_seen) begin
            odone_seen = 1;
            if (sb_orig.size() == 0) chk("orig_sb_empty", 1, 0);
            else chk("orig_data", 32'(orig_data), 32'(sb_orig.pop_front()));
        end
        if (qed_done && !qdone_seen) begin
            qdone_seen = 1;
            qed_cyc = cyc;
            if (sb_chk.size() == 0) chk("qed_sb_empty", 1, 0);
            else chk("qed_check_sb", 32'(qed_check), 32'(sb_chk.pop_front()));
        end
        if (bound_fail && bf_reads < 0) bf_reads = ren_cnt;
        cyc++;
    endtask

    function automatic logic [15:0] wordof(input int c, input vec_t v);
        if (v.dup_same && c == v.dup) return 16'(16'hA0 + v.orig);
        return 16'(16'hA0 + c);
    endfunction

    task automatic run_case(input int k, input vec_t v);
        string p;
        p = $sformatf("v%0d_", k);
        vld_en = v.vld;
        do_reset(v.depth, v.orig, v.dup, 1'b0);
        for (int c = 0; c < v.ncyc; c++) begin
            step(c < v.nwr, wordof(c, v), v.rdy, 1'b1, v.orig, v.dup);
        end
        chk({p, "orig_done"}, 32'(orig_done), 32'(v.e_odone));
        chk({p, "qed_done"}, 32'(qed_done), 32'(v.e_qdone));
        chk({p, "qed_check"}, 32'(qed_check), 32'(v.e_qchk));
        chk({p, "err_overflow"}, 32'(err_overflow), 32'(v.e_ovf));
        chk({p, "err_missing"}, 32'(err_missing), 32'(v.e_miss));
        chk({p, "err_spurious"}, 32'(err_spurious), 0);
        chk({p, "cfg_err"}, 32'(cfg_err), 32'(v.e_cfg));
        chk({p, "bound_fail"}, 32'(bound_fail), 32'(v.e_bf));
        chk({p, "occupancy"}, 32'(occupancy), 32'(v.e_occ));
        chk({p, "rd_count"}, 32'(rd_count), 32'(v.e_rd));
        chk({p, "ren_any"}, 32'(ren_any), 32'(v.e_ren));
        if (v.e_lat != 0) chk({p, "qed_latency"}, qed_cyc - first_ren, v.e_lat);
        if (v.e_bfr != 0) chk({p, "bf_reads"}, bf_reads, v.e_bfr);
    endtask

    initial begin
        vecs[0] = '{16'd4, 1, 3, 4, 1, 1, 1, 12,
                    1, 1, 1, 0, 0, 0, 0, 0, 4, 1, 4, 0};
        vecs[1] = '{16'd4, 1, 3, 4, 1, 1, 0, 12,
                    1, 1, 0, 0, 0, 0, 0, 0, 4, 1, 4, 0};
        vecs[2] = '{16'd2, 0, 1, 5, 0, 1, 0, 8,
                    0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[3] = '{16'd2, 0, 1, 10, 1, 0, 0, 14,
                    0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 9};
        vecs[4] = '{16'd4, 3, 2, 4, 1, 1, 0, 12,
                    1, 0, 0, 0, 0, 1, 0, 0, 4, 1, 0, 0};

        rtn_pend = 1'b0;
        rtn_word = '0;
        vld_en = 1'b1;
        clk_en = 1'b1;
        rdy_in = 1'b1;
        wr_fire = 1'b1;
        fifo_valid = 1'b1;
        #12;
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_ren_out", 32'(ren_out), 0);
        chk("rst_flags", {20'h0, orig_done, qed_done, qed_check, bound_fail,
                          err_spurious, err_missing, err_overflow, cfg_err,
                          4'h0}, 0);
        chk("rst_orig_data", 32'(orig_data), 0);

        for (int k = 0; k < 5; k++) run_case(k, vecs[k]);

        // clk_en pulled low between issue and return
        vld_en = 1'b1;
        do_reset(16'd4, 0, 1, 1'b0);
        step(1'b1, 16'h0055, 1'b0, 1'b1, 0, 1);
        step(1'b0, 16'h0, 1'b1, 1'b1, 0, 1);
        chk("ce_issued", ren_cnt, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 0, 1);
        chk("ce_rd_hold", 32'(rd_count), 0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 0, 1);
        chk("ce_ren_while_off", ren_dis, 0);
        chk("ce_rd_count", 32'(rd_count), 1);
        chk("ce_orig_done", 32'(orig_done), 1);
        chk("ce_err_missing", 32'(err_missing), 0);
        chk("ce_err_spurious", 32'(err_spurious), 0);

        // bad index pair is flagged after the first edge
        do_reset(16'd4, 3, 2, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 3, 2);
        chk("cfg_first_cycle", 32'(cfg_err), 1);

        // reset while a read is in flight
        do_reset(16'd4, 0, 1, 1'b0);
        step(1'b1, 16'h0077, 1'b0, 1'b1, 0, 1);
        step(1'b0, 16'h0, 1'b1, 1'b1, 0, 1);
        chk("mid_issued", ren_cnt, 1);
        do_reset(16'd4, 0, 1, 1'b1);
        chk("mid_occ_clear", 32'(occupancy), 0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 0, 1);
        chk("mid_err_spurious", 32'(err_spurious), 1);
        chk("mid_rd_count", 32'(rd_count), 0);
        chk("mid_orig_done", 32'(orig_done), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
